mips_fetch_unit: RTL

- Instruction-fetch initiator for the MIPS core; the requesting side of the main-memory read interface.
- Drives memread/address into the combinational main memory and captures each 32-bit instruction word.
- Buffers fetched words in a 2-entry queue and hands them to the decode stage over a valid/ready handshake.
- Supports PC redirect for branch/jump and stops automatically at the end of the program image.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/mips_fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS instruction-fetch unit
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // pc is held at full word width; the fetch unit uses only its low ADDR_W bits
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry FIFO of fetched {instr, pc} entries with flush
module fetch_queue
  import mips_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  q_entry_t   push_data,
  input  logic       pop,
  input  logic       flush,
  output q_entry_t   head,
  output logic [1:0] count
);

  q_entry_t   slot0_q, slot0_d;
  q_entry_t   slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push;
  logic [1:0] level;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    level   = count_q - {1'b0, do_pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      // slot0 is always the head; a pop shifts slot1 down before the push lands
      if (do_pop) slot0_d = slot1_q;
      if (do_push) begin
        if (level == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction fetch with 2-deep queue and redirect; FETCH_PERF_EN adds perf counters
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int PROG_BYTES = 284,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               memread,
  output logic               memwrite,
  output logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               misalign_err,
  output logic               done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_BYTES);
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              redirect_go, start_go;
  logic              push, pop, flush;
  logic [1:0]        count;
  q_entry_t          push_entry, head;
  logic              unused_pc_hi;

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    redirect_go      = redirect_valid && (state_q != ST_IDLE);
    start_go         = start && !redirect_go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // a full queue blocks fetch even when popping, so ready never reaches memread
    memread          = (state_q == ST_FETCH) && (count != 2'd2) && (pc_q < PROG_END) && !redirect_valid;
    address          = memread ? pc_q : '0;
    instr_valid      = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && (count != 2'd0);
    push             = memread;
    pop              = instr_valid && instr_ready && !redirect_go;
    flush            = redirect_go || start_go;
    push_entry.instr = mem_rdata;
    push_entry.pc    = PC_W'(pc_q);
    done             = (state_q == ST_DONE);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect_go) begin
      pc_d    = redirect_aligned;
      state_d = (redirect_aligned < PROG_END) ? ST_FETCH : ST_DRAIN;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (start_go) begin
      pc_d    = RST_PC;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (memread) pc_d = pc_q + STEP;
          if (pc_q >= PROG_END) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count == 2'd0) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RST_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign memwrite     = 1'b0;
  assign mem_wdata    = '0;
  assign instr        = head.instr;
  assign instr_pc     = head.pc[ADDR_W-1:0];
  assign misalign_err = misalign_q;
  assign unused_pc_hi = ^head.pc[PC_W-1:ADDR_W];

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_go) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (push && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (instr_valid && !instr_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
